// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage initiator for a word-wide, byte-enabled
// data bus. Checks alignment, raises address exceptions, places store data
// on the correct byte lanes, extracts and extends load data, and stalls the
// pipeline while a bus transfer is outstanding.
// Optional feature macro: LSU_TIMEOUT_EN (bus wait counter and busErr).
// Without it BUSY waits indefinitely for mem_ack and busErr stays 0.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic        stall,
  output logic [31:0] dout,
  output logic        done,
  output logic        addrErr,
  output logic        busErr,
  output logic [31:0] errAddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        valid;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;
  logic [31:0] rdata_shifted;
  logic        timeout_hit;
  // Access attributes kept for load extraction and bus-error reporting.
  logic [1:0]  acc_off;
  logic [1:0]  acc_size;
  logic        acc_sign;

  // Decode the request: validity and alignment of the requested access.
  always_comb begin
    valid      = req && (memSize != 2'b00) && (memRead || memWrite);
    misaligned = 1'b0;
    case (memSize)
      2'b10:   misaligned = addr[0];
      2'b11:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_next    = 4'b0000;
    wdata_next = 32'h0000_0000;
    case (memSize)
      2'b01: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{din[7:0]}};
      end
      2'b10: begin
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{din[15:0]}};
      end
      2'b11: begin
        be_next    = 4'b1111;
        wdata_next = din;
      end
      default: begin
        be_next    = 4'b0000;
        wdata_next = 32'h0000_0000;
      end
    endcase
  end

  // Select the addressed bytes of the read word and extend them to 32 bits.
  always_comb begin
    rdata_shifted = mem_rdata >> {acc_off, 3'b000};
    load_ext      = 32'h0000_0000;
    case (acc_size)
      2'b01: begin
        if (acc_sign) load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
        else          load_ext = {24'h00_0000, rdata_shifted[7:0]};
      end
      2'b10: begin
        if (acc_sign) load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
        else          load_ext = {16'h0000, rdata_shifted[15:0]};
      end
      2'b11:   load_ext = mem_rdata;
      default: load_ext = 32'h0000_0000;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wait_cnt;

  // Count BUSY cycles without an ack; cleared whenever the FSM is not BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= {CW{1'b0}};
    end else if (state != BUSY) begin
      wait_cnt <= {CW{1'b0}};
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  assign timeout_hit = (state == BUSY) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state logic; an ack in the timeout cycle takes priority.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (valid && misaligned) next_state = ERR;
        else if (valid)          next_state = BUSY;
        else                     next_state = IDLE;
      end
      BUSY: begin
        if (mem_ack)          next_state = DONE;
        else if (timeout_hit) next_state = ERR;
        else                  next_state = BUSY;
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Bus outputs, load result and status pulses, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      dout      <= 32'h0000_0000;
      done      <= 1'b0;
      addrErr   <= 1'b0;
      busErr    <= 1'b0;
      errAddr   <= 32'h0000_0000;
      acc_off   <= 2'b00;
      acc_size  <= 2'b00;
      acc_sign  <= 1'b0;
    end else begin
      done    <= 1'b0;
      addrErr <= 1'b0;
      busErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && misaligned) begin
            addrErr <= 1'b1;
            errAddr <= addr;
          end else if (valid) begin
            mem_req   <= 1'b1;
            mem_we    <= memWrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
            acc_off   <= addr[1:0];
            acc_size  <= memSize;
            acc_sign  <= memSign;
          end else begin
            mem_req <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) dout <= load_ext;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            busErr  <= 1'b1;
            errAddr <= {mem_addr[31:2], acc_off};
          end else begin
            mem_req <= 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  // Stall while an aligned access is being accepted or the bus is busy.
  assign stall = rst && (((state == IDLE) && valid && !misaligned) || (state == BUSY));

endmodule
